// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types for the memory side of the pipelined datapath.
//   word_t      - 32-bit machine word
//   ramstate_t  - status reported by the RAM model/controller
//   arb_state_t - memory_arbiter FSM states
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2,
        RESP = 2'd3
    } arb_state_t;

endpackage

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares the single RAM port between instruction fetch and
// data access. Data has priority; after DSTREAK_MAX consecutive data grants
// with a fetch waiting, the fetch is granted (DSTREAK_MAX=0: strict data
// priority). An access that sees neither ACCESS nor ERROR within TIMEOUT
// cycles completes with fault.
//
// state | meaning
// IDLE  | no access in flight; requests are arbitrated here
// IACC  | fetch on the RAM port, waiting for ACCESS
// DACC  | data read/write on the RAM port, waiting for ACCESS
// RESP  | one-cycle ihit/dhit (and fault) pulse; requests ignored
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   iREN, iaddr              fetch request (held until ihit) and address
//   dREN, dWEN, daddr, dstore data request (held until dhit), address, data
//   ihit, iload              fetch completion pulse, fetched word (held)
//   dhit, dload              data completion pulse, read word (held)
//   fault                    pulse with the hit on RAM ERROR or timeout
//   busy                     high whenever the FSM is not IDLE
//   ramREN, ramWEN, ramaddr, ramstore   registered RAM request
//   ramload, ramstate        RAM read data and status
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int DSTREAK_MAX = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      ihit,
    output word_t     iload,
    output logic      dhit,
    output word_t     dload,
    output logic      fault,
    output logic      busy,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate
);

    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int SW = (DSTREAK_MAX > 0) ? $clog2(DSTREAK_MAX + 1) : 1;
    localparam logic [TW-1:0] TCNT_LAST  = TW'(TIMEOUT);
    localparam logic [SW-1:0] STREAK_MAX = SW'(DSTREAK_MAX);

    arb_state_t    state, state_n;
    logic          ren_n, wen_n;
    word_t         addr_n, store_n, iload_n, dload_n;
    logic [SW-1:0] dstreak, dstreak_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic          rsp_data, rsp_data_n;   // RESP belongs to the data side
    logic          fault_arm, fault_arm_n;
    logic          data_pend, fetch_starved;

    assign data_pend     = dREN | dWEN;
    assign fetch_starved = iREN && (DSTREAK_MAX != 0) && (dstreak == STREAK_MAX);

    assign busy  = (state != IDLE);
    assign ihit  = (state == RESP) && !rsp_data;
    assign dhit  = (state == RESP) && rsp_data;
    assign fault = (state == RESP) && fault_arm;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            ramREN    <= 1'b0;
            ramWEN    <= 1'b0;
            ramaddr   <= '0;
            ramstore  <= '0;
            iload     <= '0;
            dload     <= '0;
            dstreak   <= '0;
            tcnt      <= '0;
            rsp_data  <= 1'b0;
            fault_arm <= 1'b0;
        end else begin
            state     <= state_n;
            ramREN    <= ren_n;
            ramWEN    <= wen_n;
            ramaddr   <= addr_n;
            ramstore  <= store_n;
            iload     <= iload_n;
            dload     <= dload_n;
            dstreak   <= dstreak_n;
            tcnt      <= tcnt_n;
            rsp_data  <= rsp_data_n;
            fault_arm <= fault_arm_n;
        end
    end

    always_comb begin
        state_n     = state;
        ren_n       = ramREN;
        wen_n       = ramWEN;
        addr_n      = ramaddr;
        store_n     = ramstore;
        iload_n     = iload;
        dload_n     = dload;
        dstreak_n   = dstreak;
        tcnt_n      = tcnt;
        rsp_data_n  = rsp_data;
        fault_arm_n = fault_arm;

        unique case (state)
            IDLE: begin
                if (data_pend && !fetch_starved) begin
                    addr_n      = daddr;
                    store_n     = dstore;
                    wen_n       = dWEN;
                    ren_n       = dREN & ~dWEN;   // write wins if both set
                    rsp_data_n  = 1'b1;
                    fault_arm_n = 1'b0;
                    tcnt_n      = '0;
                    state_n     = DACC;
                    // The streak only counts data grants that kept a fetch waiting.
                    if (iREN)
                        dstreak_n = (dstreak == STREAK_MAX) ? dstreak : dstreak + SW'(1);
                    else
                        dstreak_n = '0;
                end else if (iREN) begin
                    addr_n      = iaddr;
                    ren_n       = 1'b1;
                    wen_n       = 1'b0;
                    rsp_data_n  = 1'b0;
                    fault_arm_n = 1'b0;
                    tcnt_n      = '0;
                    dstreak_n   = '0;
                    state_n     = IACC;
                end
            end
            IACC, DACC: begin
                tcnt_n = tcnt + TW'(1);
                if (ramstate == ACCESS) begin
                    ren_n   = 1'b0;
                    wen_n   = 1'b0;
                    state_n = RESP;
                    if (state == IACC)
                        iload_n = ramload;
                    else if (!ramWEN)
                        dload_n = ramload;
                end else if (ramstate == ERROR || tcnt == TCNT_LAST) begin
                    ren_n       = 1'b0;
                    wen_n       = 1'b0;
                    fault_arm_n = 1'b1;
                    state_n     = RESP;
                    if (state == IACC)
                        iload_n = '0;
                    else
                        dload_n = '0;
                end
            end
            RESP: begin
                state_n     = IDLE;
                tcnt_n      = '0;
                fault_arm_n = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    localparam int DSMAX = 2;
    localparam int TMO   = 3;

    logic      CLK = 1'b0;
    logic      RST;
    logic      iREN, dREN, dWEN;
    word_t     iaddr, daddr, dstore;
    logic      ihit, dhit, fault, busy, ramREN, ramWEN;
    word_t     iload, dload, ramaddr, ramstore, ramload;
    ramstate_t ramstate;

    memory_arbiter #(.DSTREAK_MAX(DSMAX), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .ihit(ihit), .iload(iload), .dhit(dhit), .dload(dload),
        .fault(fault), .busy(busy),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    task automatic chk1(input string nm, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %b want %b", nm, $time, got, exp);
        end
    endtask

    task automatic chk32(input string nm, input word_t got, input word_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h want %h", nm, $time, got, exp);
        end
    endtask

    // RAM responder: ACCESS (or ERROR) on the rdelay-th strobe cycle; STUCK never answers.
    localparam int R_ACC = 0, R_ERR = 1, R_STUCK = 2;
    int    rmode = R_ACC;
    int    rdelay = 1;
    int    rcnt = 0;
    word_t rdata = '0;

    always @(negedge CLK) begin
        if (ramREN || ramWEN) begin
            rcnt++;
            if (rmode == R_STUCK)      ramstate = BUSY;
            else if (rcnt == rdelay)   ramstate = (rmode == R_ERR) ? ERROR : ACCESS;
            else                       ramstate = BUSY;
        end else begin
            rcnt = 0;
            ramstate = FREE;
        end
        ramload = rdata;
    end

    // Transaction-level model: one access at a time, described by its grant
    // cycle and the cycle its response pulse is due.
    int    cyc = 0;
    bit    m_act, m_d, m_wr, m_fault;
    int    m_start, m_hit, m_streak;
    word_t m_addr, m_store, m_il, m_dl;

    always @(posedge CLK) begin
        cyc++;
        if (RST) begin
            m_act = 0; m_hit = -1; m_fault = 0; m_streak = 0;
            m_il = '0; m_dl = '0; m_addr = '0; m_store = '0; m_d = 0; m_wr = 0;
        end else if (m_act) begin
            if (m_hit == cyc - 1) begin
                m_act = 0;
            end else if (m_hit < 0) begin
                if (ramstate == ACCESS || ramstate == ERROR || (cyc - 1 - m_start) == TMO) begin
                    m_hit   = cyc;
                    m_fault = (ramstate != ACCESS);
                    if (!m_d)      m_il = m_fault ? '0 : ramload;
                    else if (m_fault) m_dl = '0;
                    else if (!m_wr)   m_dl = ramload;
                end
            end
        end else begin
            if ((dREN || dWEN) && !(iREN && DSMAX != 0 && m_streak == DSMAX)) begin
                m_act = 1; m_d = 1; m_wr = dWEN; m_addr = daddr; m_store = dstore;
                m_start = cyc; m_hit = -1;
                m_streak = iREN ? ((m_streak < DSMAX) ? m_streak + 1 : m_streak) : 0;
            end else if (iREN) begin
                m_act = 1; m_d = 0; m_wr = 0; m_addr = iaddr;
                m_start = cyc; m_hit = -1; m_streak = 0;
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_on) begin
            bit strobe;
            strobe = m_act && (m_hit < 0);
            chk1("busy",   busy,   m_act);
            chk1("ihit",   ihit,   m_act && m_hit == cyc && !m_d);
            chk1("dhit",   dhit,   m_act && m_hit == cyc && m_d);
            chk1("fault",  fault,  m_act && m_hit == cyc && m_fault);
            chk1("ramREN", ramREN, strobe && !(m_d && m_wr));
            chk1("ramWEN", ramWEN, strobe && m_d && m_wr);
            if (strobe) chk32("ramaddr", ramaddr, m_addr);
            if (strobe && m_d) chk32("ramstore", ramstore, m_store);
            chk32("iload", iload, m_il);
            chk32("dload", dload, m_dl);
        end
    end

    // Grant order log: one letter per rising RAM strobe.
    bit    log_on = 1'b0;
    bit    prev_strobe = 1'b0;
    string glog = "";
    int    nlog = 0;

    always @(negedge CLK) begin
        if (log_on && (ramREN || ramWEN) && !prev_strobe) begin
            glog = {glog, (ramaddr == 32'h80) ? "I" : "D"};
            nlog++;
        end
        prev_strobe = ramREN || ramWEN;
    end

    task automatic wait_hit(input bit d, input int budget, input string nm);
        int n = 0;
        while (!(d ? dhit : ihit) && n < budget) begin
            @(negedge CLK);
            n++;
        end
        if (!(d ? dhit : ihit)) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: no hit within %0d cycles (want a hit)", nm, budget);
        end
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge CLK);
            n++;
        end
        if (busy) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: busy=1 after %0d cycles (want 0)", nm, budget);
        end
    endtask

    initial begin
        RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = '0; daddr = '0; dstore = '0;
        ramstate = FREE; ramload = '0;
        @(negedge CLK);
        chk_on = 1'b1;
        @(negedge CLK);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_ramREN", ramREN, 1'b0);
        chk32("rst_ramaddr", ramaddr, 32'h0);
        chk32("rst_iload", iload, 32'h0);
        RST = 1'b0;
        @(negedge CLK);

        // Fetch only: ACCESS on 2nd strobe cycle, ihit at cycle 3.
        rmode = R_ACC; rdelay = 2; rdata = 32'h8C220004;
        iaddr = 32'h40; iREN = 1;
        @(negedge CLK);
        chk1("f_busy1", busy, 1'b1);
        chk1("f_ren1", ramREN, 1'b1);
        chk32("f_addr1", ramaddr, 32'h40);
        chk1("f_ihit1", ihit, 1'b0);
        @(negedge CLK);
        chk1("f_busy2", busy, 1'b1);
        chk1("f_ihit2", ihit, 1'b0);
        @(negedge CLK);
        chk1("f_ihit3", ihit, 1'b1);
        chk32("f_iload", iload, 32'h8C220004);
        iREN = 0;
        @(negedge CLK);
        chk1("f_ihit4", ihit, 1'b0);
        chk1("f_busy4", busy, 1'b0);

        // Contention: data first, fetch granted in the IDLE after RESP.
        rdelay = 1; rdata = 32'h11110000;
        iaddr = 32'h44; daddr = 32'h100; iREN = 1; dREN = 1;
        @(negedge CLK);
        chk32("c_daddr", ramaddr, 32'h100);
        chk1("c_dren", ramREN, 1'b1);
        @(negedge CLK);
        chk1("c_dhit", dhit, 1'b1);
        chk32("c_dload", dload, 32'h11110000);
        dREN = 0;
        @(negedge CLK);
        chk1("c_idle", busy, 1'b0);
        @(negedge CLK);
        chk32("c_iaddr", ramaddr, 32'h44);
        chk1("c_iren", ramREN, 1'b1);
        @(negedge CLK);
        chk1("c_ihit", ihit, 1'b1);
        iREN = 0;
        @(negedge CLK);

        // Write: address/data sampled only at grant, dload untouched.
        rdelay = 2;
        dWEN = 1; daddr = 32'h200; dstore = 32'hDEADBEEF;
        @(negedge CLK);
        chk1("w_wen", ramWEN, 1'b1);
        chk1("w_ren", ramREN, 1'b0);
        chk32("w_addr", ramaddr, 32'h200);
        chk32("w_store", ramstore, 32'hDEADBEEF);
        daddr = 32'h999; dstore = 32'h12345678;
        @(negedge CLK);
        chk32("w_addr_held", ramaddr, 32'h200);
        chk32("w_store_held", ramstore, 32'hDEADBEEF);
        @(negedge CLK);
        chk1("w_dhit", dhit, 1'b1);
        chk32("w_dload", dload, 32'h11110000);
        dWEN = 0;
        @(negedge CLK);

        // RAM ERROR in DACC.
        rmode = R_ERR; rdelay = 1;
        dREN = 1; daddr = 32'h300;
        @(negedge CLK);
        @(negedge CLK);
        chk1("e_dhit", dhit, 1'b1);
        chk1("e_fault", fault, 1'b1);
        chk32("e_dload", dload, 32'h0);
        dREN = 0;
        @(negedge CLK);

        // Timeout: RAM stuck BUSY, fault TIMEOUT+1 cycles after entering DACC.
        rmode = R_STUCK;
        dREN = 1; daddr = 32'h304;
        repeat (4) @(negedge CLK);
        chk1("t_fault4", fault, 1'b0);
        @(negedge CLK);
        chk1("t_fault5", fault, 1'b1);
        chk1("t_dhit5", dhit, 1'b1);
        dREN = 0;
        @(negedge CLK);

        // Reset in IACC aborts the access; a fresh fetch runs normally.
        rmode = R_ACC; rdelay = 3; rdata = 32'hCAFE0048;
        iaddr = 32'h48; iREN = 1;
        @(negedge CLK);
        chk1("r_ren_pre", ramREN, 1'b1);
        RST = 1;
        @(negedge CLK);
        chk1("r_ren", ramREN, 1'b0);
        chk1("r_busy", busy, 1'b0);
        chk1("r_ihit", ihit, 1'b0);
        RST = 0;
        @(negedge CLK);
        wait_hit(1'b0, 10, "r_regrant");
        chk32("r_iload", iload, 32'hCAFE0048);
        iREN = 0;
        @(negedge CLK);
        wait_idle(5, "r_idle");

        // Starvation bound: DSTREAK_MAX=2 gives D, D, I, D, D, I.
        rdelay = 1; rdata = 32'h55AA0000;
        iaddr = 32'h80; daddr = 32'h180;
        log_on = 1; iREN = 1; dREN = 1;
        for (int n = 0; n < 60 && nlog < 6; n++) @(negedge CLK);
        iREN = 0; dREN = 0; log_on = 0;
        wait_idle(10, "s_idle");
        n_cmp++;
        if (glog != "DDIDDI") begin
            n_bad++;
            $display("FAIL s_order: got %s want DDIDDI", glog);
        end
        repeat (2) @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (want finish before 100000)");
        $fatal(1);
    end

endmodule
